pll_lock_supervisor: RTL and testbench



---
 rtl/pll_sup_pkg.sv | 23 ++
 rtl/sync_bit.sv | 22 ++
 rtl/pll_lock_supervisor.sv | 116 +++++++++++
 tb/tb_pll_lock_supervisor.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/pll_sup_pkg.sv
// Shared definitions for the PLL lock supervisor: state encoding and the
// width helper for the shared cycle counter.
package pll_sup_pkg;

  // FSM state codes, also exported on the debug state port.
  localparam logic [2:0] ST_RST_PLL   = 3'd0;
  localparam logic [2:0] ST_WAIT_LOCK = 3'd1;
  localparam logic [2:0] ST_STABLE    = 3'd2;
  localparam logic [2:0] ST_RUN       = 3'd3;
  localparam logic [2:0] ST_FAIL      = 3'd4;

  // Counter width: $clog2 of the largest cycle parameter, plus one bit.
  function automatic int unsigned cnt_width(input int unsigned a,
                                            input int unsigned b,
                                            input int unsigned c);
    int unsigned m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return $clog2(m) + 1;
  endfunction

endpackage

// File: rtl/sync_bit.sv
// Multi-flop synchronizer for a single asynchronous input bit.
// Ports: clk, rst_n (async active-low), d (async input), q (synchronized).
module sync_bit #(
  parameter int unsigned STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] sync_q;

  // Shift chain; q is d delayed by STAGES clocks.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sync_q <= '0;
    else        sync_q <= {sync_q[STAGES-2:0], d};
  end

  assign q = sync_q[STAGES-1];

endmodule

// File: rtl/pll_lock_supervisor.sv
// PLL lock supervisor: sequences the PLL reset, waits for a stable lock,
// releases the system reset, and retries or fails when lock never arrives.
// Ports: refclk/rst_n (clock, async active-low reset), pll_locked (async lock
// input), restart (re-init pulse), pll_rst, sys_rst_n, ready, fail, lock_lost,
// retry_cnt, state (debug).
module pll_lock_supervisor
  import pll_sup_pkg::*;
#(
  parameter int unsigned RST_CYCLES    = 16,
  parameter int unsigned LOCK_TIMEOUT  = 50000,
  parameter int unsigned STABLE_CYCLES = 1024,
  parameter int unsigned MAX_RETRIES   = 3,
  parameter int unsigned SYNC_STAGES   = 2
) (
  input  logic                               refclk,
  input  logic                               rst_n,
  input  logic                               pll_locked,
  input  logic                               restart,
  output logic                               pll_rst,
  output logic                               sys_rst_n,
  output logic                               ready,
  output logic                               fail,
  output logic                               lock_lost,
  output logic [$clog2(MAX_RETRIES+1)-1:0]   retry_cnt,
  output logic [2:0]                         state
);

  localparam int unsigned CW = cnt_width(RST_CYCLES, LOCK_TIMEOUT, STABLE_CYCLES);
  localparam int unsigned RW = $clog2(MAX_RETRIES + 1);

  logic          locked_s;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    state_d;
  logic [RW-1:0] retry_d;
  logic          lock_lost_d;

  sync_bit #(.STAGES(SYNC_STAGES)) u_lock_sync (
    .clk   (refclk),
    .rst_n (rst_n),
    .d     (pll_locked),
    .q     (locked_s)
  );

  // Next-state, retry count, sticky flag and shared counter.
  always_comb begin
    state_d     = state;
    retry_d     = retry_cnt;
    lock_lost_d = lock_lost;
    if (restart) begin
      state_d     = ST_RST_PLL;
      retry_d     = '0;
      lock_lost_d = 1'b0;
    end else begin
      case (state)
        ST_RST_PLL: begin
          if (cnt_q == CW'(RST_CYCLES - 1)) state_d = ST_WAIT_LOCK;
        end
        ST_WAIT_LOCK: begin
          // Lock takes precedence over a coincident timeout.
          if (locked_s) begin
            state_d = ST_STABLE;
          end else if (cnt_q == CW'(LOCK_TIMEOUT - 1)) begin
            if (retry_cnt == RW'(MAX_RETRIES)) begin
              state_d = ST_FAIL;
            end else begin
              retry_d = retry_cnt + RW'(1);
              state_d = ST_RST_PLL;
            end
          end
        end
        ST_STABLE: begin
          if (!locked_s)                            state_d = ST_WAIT_LOCK;
          else if (cnt_q == CW'(STABLE_CYCLES - 1)) state_d = ST_RUN;
        end
        ST_RUN: begin
          if (!locked_s) begin
            state_d     = ST_RST_PLL;
            retry_d     = '0;
            lock_lost_d = 1'b1;
          end
        end
        ST_FAIL: state_d = ST_FAIL;
        default: state_d = ST_RST_PLL;
      endcase
    end

    // Counter restarts on every state change or restart; idle in RUN/FAIL.
    if (restart || (state_d != state))             cnt_d = '0;
    else if ((state == ST_RUN) || (state == ST_FAIL)) cnt_d = cnt_q;
    else                                           cnt_d = cnt_q + CW'(1);
  end

  // All outputs are registered from the next state so they change with it.
  always_ff @(posedge refclk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_RST_PLL;
      cnt_q     <= '0;
      retry_cnt <= '0;
      lock_lost <= 1'b0;
      pll_rst   <= 1'b1;
      sys_rst_n <= 1'b0;
      ready     <= 1'b0;
      fail      <= 1'b0;
    end else begin
      state     <= state_d;
      cnt_q     <= cnt_d;
      retry_cnt <= retry_d;
      lock_lost <= lock_lost_d;
      pll_rst   <= (state_d == ST_RST_PLL) || (state_d == ST_FAIL);
      sys_rst_n <= (state_d == ST_RUN);
      ready     <= (state_d == ST_RUN);
      fail      <= (state_d == ST_FAIL);
    end
  end

endmodule

// File: tb/tb_pll_lock_supervisor.sv
// Directed bench for pll_lock_supervisor with small cycle parameters.
module tb_pll_lock_supervisor;

  logic       refclk;
  logic       rst_n;
  logic       pll_locked;
  logic       restart;
  logic       pll_rst;
  logic       sys_rst_n;
  logic       ready;
  logic       fail;
  logic       lock_lost;
  logic [1:0] retry_cnt;
  logic [2:0] state;

  int n_chk  = 0;
  int n_fail = 0;

  pll_lock_supervisor #(
    .RST_CYCLES    (4),
    .LOCK_TIMEOUT  (20),
    .STABLE_CYCLES (8),
    .MAX_RETRIES   (2),
    .SYNC_STAGES   (2)
  ) dut (
    .refclk     (refclk),
    .rst_n      (rst_n),
    .pll_locked (pll_locked),
    .restart    (restart),
    .pll_rst    (pll_rst),
    .sys_rst_n  (sys_rst_n),
    .ready      (ready),
    .fail       (fail),
    .lock_lost  (lock_lost),
    .retry_cnt  (retry_cnt),
    .state      (state)
  );

  initial refclk = 1'b0;
  always #5 refclk = ~refclk;

  // Per-row stimulus held for 'cycles' edges, with outputs checked after each.
  typedef struct {
    int unsigned cycles;
    logic        locked;
    logic        rstrt;
    logic [2:0]  st;
    logic        prst;
    logic        srst;
    logic        rdy;
    logic        fl;
    logic        lost;
    logic [1:0]  retry;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input int unsigned c, input logic lk, input logic rs,
                     input logic [2:0] st, input logic prst, input logic srst,
                     input logic rdy, input logic fl, input logic lost,
                     input logic [1:0] retry);
    vec_t v;
    v.cycles = c; v.locked = lk; v.rstrt = rs; v.st = st; v.prst = prst;
    v.srst = srst; v.rdy = rdy; v.fl = fl; v.lost = lost; v.retry = retry;
    vecs.push_back(v);
  endtask

  task automatic tick;
    @(posedge refclk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  function automatic logic [9:0] obs();
    return {state, pll_rst, sys_rst_n, ready, fail, lock_lost, retry_cnt};
  endfunction

  localparam logic [9:0] RESET_OBS = {3'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0};

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    logic [9:0] e;

    rst_n = 1'b0; pll_locked = 1'b0; restart = 1'b0;
    repeat (3) @(posedge refclk);
    #1;
    chk("reset_values", 32'(obs()), 32'(RESET_OBS));
    rst_n = 1'b1;

    // Bring-up: lock 5 cycles after pll_rst falls, release 2 sync + 1 + 8 later.
    add(3, 0, 0, 3'd0, 1, 0, 0, 0, 0, 2'd0);
    add(6, 0, 0, 3'd1, 0, 0, 0, 0, 0, 2'd0);
    add(2, 1, 0, 3'd1, 0, 0, 0, 0, 0, 2'd0);
    add(8, 1, 0, 3'd2, 0, 0, 0, 0, 0, 2'd0);
    add(3, 1, 0, 3'd3, 0, 1, 1, 0, 0, 2'd0);
    // Lock loss in RUN: detected on the 3rd edge, 4-cycle pll_rst, relock.
    add(2, 0, 0, 3'd3, 0, 1, 1, 0, 0, 2'd0);
    add(1, 0, 0, 3'd0, 1, 0, 0, 0, 1, 2'd0);
    add(3, 0, 0, 3'd0, 1, 0, 0, 0, 1, 2'd0);
    add(2, 1, 0, 3'd1, 0, 0, 0, 0, 1, 2'd0);
    add(8, 1, 0, 3'd2, 0, 0, 0, 0, 1, 2'd0);
    add(2, 1, 0, 3'd3, 0, 1, 1, 0, 1, 2'd0);
    // Restart clears lock_lost, then a one-cycle lock glitch during STABLE.
    add(1, 1, 1, 3'd0, 1, 0, 0, 0, 0, 2'd0);
    add(3, 1, 0, 3'd0, 1, 0, 0, 0, 0, 2'd0);
    add(1, 1, 0, 3'd1, 0, 0, 0, 0, 0, 2'd0);
    add(5, 1, 0, 3'd2, 0, 0, 0, 0, 0, 2'd0);
    add(1, 0, 0, 3'd2, 0, 0, 0, 0, 0, 2'd0);
    add(1, 1, 0, 3'd2, 0, 0, 0, 0, 0, 2'd0);
    add(1, 1, 0, 3'd1, 0, 0, 0, 0, 0, 2'd0);
    add(8, 1, 0, 3'd2, 0, 0, 0, 0, 0, 2'd0);
    add(1, 1, 0, 3'd3, 0, 1, 1, 0, 0, 2'd0);

    foreach (vecs[i]) begin
      e = {vecs[i].st, vecs[i].prst, vecs[i].srst, vecs[i].rdy,
           vecs[i].fl, vecs[i].lost, vecs[i].retry};
      for (int c = 0; c < int'(vecs[i].cycles); c++) begin
        pll_locked = vecs[i].locked;
        restart    = vecs[i].rstrt;
        tick();
        chk($sformatf("vec%0d_cyc%0d", i, c), 32'(obs()), 32'(e));
      end
    end
    restart = 1'b0;

    // Restart on the same cycle the synchronized lock falls in RUN.
    pll_locked = 1'b0;
    tick();
    tick();
    chk("run_before_restart", 32'(state), 32'(3));
    restart = 1'b1;
    tick();
    restart = 1'b0;
    chk("restart_vs_loss_state", 32'(state), 32'(0));
    chk("restart_vs_loss_lost", 32'(lock_lost), 32'(0));
    chk("restart_vs_loss_sysrst", 32'({sys_rst_n, ready}), 32'(0));

    // No lock at all: three 24-cycle attempts, then FAIL.
    for (int t = 1; t <= 72; t++) begin
      tick();
      if (t == 24) chk("retry1", 32'({state, retry_cnt}), 32'({3'd0, 2'd1}));
      if (t == 48) chk("retry2", 32'({state, retry_cnt}), 32'({3'd0, 2'd2}));
      if (t == 71) chk("pre_fail", 32'({state, fail}), 32'({3'd1, 1'b0}));
      if (t == 72) chk("fail_entry", 32'(obs()),
                       32'({3'd4, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 2'd2}));
    end
    repeat (5) tick();
    chk("fail_sticky", 32'({state, pll_rst, fail}), 32'({3'd4, 1'b1, 1'b1}));
    restart = 1'b1;
    tick();
    restart = 1'b0;
    chk("fail_restart", 32'({state, fail, retry_cnt}), 32'({3'd0, 1'b0, 2'd0}));
    n = 0;
    while (pll_rst && n < 50) begin n++; tick(); end
    chk("restart_pll_rst_len", 32'(n), 32'(4));

    // Async reset while in STABLE with cnt=6.
    pll_locked = 1'b1;
    repeat (9) tick();
    chk("stable_cnt6", 32'({state, ready}), 32'({3'd2, 1'b0}));
    rst_n = 1'b0;
    #1;
    chk("async_reset_values", 32'(obs()), 32'(RESET_OBS));
    repeat (2) @(posedge refclk);
    #1;
    rst_n = 1'b1;
    n = 0;
    while (pll_rst && n < 50) begin n++; tick(); end
    chk("post_reset_pll_rst_len", 32'(n), 32'(4));
    chk("post_reset_wait", 32'(state), 32'(1));
    tick();
    chk("post_reset_stable", 32'(state), 32'(2));

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
